// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - op encodings and the per-bit reduce function shared by both pipeline stages
package logic_pkg;

    localparam logic [1:0] OP_OR  = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOR = 2'd3;

    function automatic logic reduce_op(input logic [1:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reduce_half.sv
// rtl/reduce_half.sv - combinational bitwise fold of N words with one op
// op_i must be OR, AND or XOR; folding NOR word by word would not be associative.
module reduce_half
    import logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic [1:0]         op_i,
    input  logic [N*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]   res_o
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] word;

    always_comb begin
        acc  = data_i[WIDTH-1:0];
        word = '0;
        for (int k = 1; k < N; k++) begin
            word = data_i[k*WIDTH +: WIDTH];
            for (int b = 0; b < WIDTH; b++) begin
                acc[b] = reduce_op(op_i, acc[b], word[b]);
            end
        end
    end

    assign res_o = acc;

endmodule

// File: rtl/logic_reduce_pipe.sv
// rtl/logic_reduce_pipe.sv - two-stage elastic bitwise reducer with saturating result counter
module logic_reduce_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [1:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [1:0]              out_op,
    output logic                    out_zero,
    output logic [CNT_W-1:0]        res_count
);

    localparam int HALF = NUM_IN / 2;

    if (NUM_IN < 2 || NUM_IN > 16 || (NUM_IN % 2) != 0) begin : g_bad_num_in
        $error("logic_reduce_pipe: NUM_IN must be even and within 2..16");
    end

    logic                 s1_valid_q, s2_valid_q;
    logic                 s1_ready, s2_ready;
    logic                 s1_load, s2_load;
    logic [1:0]           half_op;
    logic [WIDTH-1:0]     lo_d, hi_d, lo_q, hi_q;
    logic [1:0]           s1_op_q;
    logic [WIDTH-1:0]     out_data_d, out_data_q;
    logic [1:0]           out_op_q;
    logic                 out_zero_q;
    logic [CNT_W-1:0]     res_count_d, res_count_q;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;
    assign s1_load  = in_valid && s1_ready;
    assign s2_load  = s1_valid_q && s2_ready;

    // NOR is carried as OR through stage 1 and inverted once in stage 2.
    assign half_op = (in_op == OP_NOR) ? OP_OR : in_op;

    reduce_half #(.WIDTH(WIDTH), .N(HALF)) u_lo (
        .op_i   (half_op),
        .data_i (in_data[HALF*WIDTH-1:0]),
        .res_o  (lo_d)
    );

    reduce_half #(.WIDTH(WIDTH), .N(HALF)) u_hi (
        .op_i   (half_op),
        .data_i (in_data[NUM_IN*WIDTH-1 -: HALF*WIDTH]),
        .res_o  (hi_d)
    );

    always_comb begin
        out_data_d = '0;
        for (int b = 0; b < WIDTH; b++) begin
            out_data_d[b] = reduce_op(s1_op_q, lo_q[b], hi_q[b]);
        end
    end

    assign res_count_d = (res_count_q == {CNT_W{1'b1}}) ? res_count_q : res_count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            s1_op_q     <= OP_OR;
            out_data_q  <= '0;
            out_op_q    <= OP_OR;
            out_zero_q  <= 1'b1;
            res_count_q <= '0;
        end else begin
            if (s1_load) begin
                lo_q       <= lo_d;
                hi_q       <= hi_d;
                s1_op_q    <= in_op;
                s1_valid_q <= 1'b1;
            end else if (s2_ready) begin
                s1_valid_q <= 1'b0;
            end

            if (s2_load) begin
                out_data_q <= out_data_d;
                out_op_q   <= s1_op_q;
                out_zero_q <= (out_data_d == '0);
                s2_valid_q <= 1'b1;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end

            if (s2_valid_q && out_ready) begin
                res_count_q <= res_count_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_op    = out_op_q;
    assign out_zero  = out_zero_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// tb/tb_logic_reduce_pipe.sv - scoreboard bench for logic_reduce_pipe
module tb_logic_reduce_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_op = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_op;
    logic        out_zero;
    logic [15:0] res_count;

    logic        sat_reset = 1'b1;
    logic        sat_in_valid = 1'b0;
    logic        sat_in_ready;
    logic [31:0] sat_in_data = '0;
    logic [1:0]  sat_in_op = 2'd0;
    logic        sat_out_valid;
    logic        sat_out_ready = 1'b0;
    logic [7:0]  sat_out_data;
    logic [1:0]  sat_out_op;
    logic        sat_out_zero;
    logic [3:0]  sat_res_count;

    always #5 clk = ~clk;

    logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .res_count (res_count)
    );

    logic_reduce_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .reset     (sat_reset),
        .in_valid  (sat_in_valid),
        .in_ready  (sat_in_ready),
        .in_data   (sat_in_data),
        .in_op     (sat_in_op),
        .out_valid (sat_out_valid),
        .out_ready (sat_out_ready),
        .out_data  (sat_out_data),
        .out_op    (sat_out_op),
        .out_zero  (sat_out_zero),
        .res_count (sat_res_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-vector reference: fold all four words directly, NOR inverts the final OR.
    function automatic logic [7:0] ref_reduce(input logic [1:0] op, input logic [31:0] d);
        logic [7:0] acc;
        acc = (op == 2'd1) ? 8'hFF : 8'h00;
        for (int k = 0; k < 4; k++) begin
            case (op)
                2'd1:    acc = acc & d[k*8 +: 8];
                2'd2:    acc = acc ^ d[k*8 +: 8];
                default: acc = acc | d[k*8 +: 8];
            endcase
        end
        return (op == 2'd3) ? ~acc : acc;
    endfunction

    logic [9:0]  sb[$];
    logic        mon_en = 1'b0;
    logic [15:0] model_cnt = '0;
    logic        hold_prev = 1'b0;
    logic [7:0]  data_prev = '0;
    logic [1:0]  op_prev = '0;
    int          sat_xfers = 0;
    logic [3:0]  sat_model = '0;
    logic        sat_mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            logic [9:0] e;
            check_eq("res_count", res_count, model_cnt);
            if (hold_prev) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, data_prev);
                check_eq("hold_op", out_op, op_prev);
            end
            if (reset) begin
                sb.delete();
                model_cnt = '0;
                hold_prev = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    check_eq("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_eq("out_data", out_data, e[7:0]);
                        check_eq("out_op", out_op, e[9:8]);
                        check_eq("out_zero", out_zero, e[7:0] == 8'h00);
                    end
                    if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 1'b1;
                end
                if (in_valid && in_ready) sb.push_back({in_op, ref_reduce(in_op, in_data)});
                hold_prev = out_valid && !out_ready;
                data_prev = out_data;
                op_prev   = out_op;
            end
        end
        if (sat_mon_en) begin
            check_eq("sat_count", sat_res_count, sat_model);
            if (sat_out_valid && sat_out_ready) begin
                sat_xfers++;
                if (sat_model != 4'hF) sat_model = sat_model + 1'b1;
            end
        end
    end

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq(tag, (sb.size() == 0) && !out_valid, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_directed(input logic [1:0] op, input logic [7:0] exp, input string tag);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_data   = 32'h8004_0201;
        @(negedge clk);
        check_eq({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check_eq({tag, "_lat2"}, out_valid, 1);
        check_eq({tag, "_data"}, out_data, exp);
        check_eq({tag, "_zero"}, out_zero, exp == 8'h00);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        sat_reset = 1'b0;
        mon_en    = 1'b1;
        sat_mon_en = 1'b1;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_zero", out_zero, 1);
        check_eq("rst_out_data", out_data, 0);

        send_directed(2'd0, 8'h87, "op_or");
        send_directed(2'd1, 8'h00, "op_and");
        send_directed(2'd2, 8'h87, "op_xor");
        send_directed(2'd3, 8'h78, "op_nor");
        drain("drain_ops");

        // Back-pressure: two beats fill the pipe, the third must wait.
        do_reset(1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'd2;
        in_data   = 32'h1122_3344;
        @(negedge clk);
        check_eq("bp_rdy0", in_ready, 1);
        @(posedge clk); #1;
        in_op   = 2'd1;
        in_data = 32'hF0FF_F3F7;
        @(negedge clk);
        check_eq("bp_rdy1", in_ready, 1);
        @(posedge clk); #1;
        in_op   = 2'd3;
        in_data = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("bp_full", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("drain_bp");
        @(negedge clk);
        check_eq("bp_count", res_count, 3);

        // Full throughput: one beat accepted and one result produced per cycle.
        do_reset(1);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_data  = $urandom;
            @(negedge clk);
            check_eq("tp_rdy", in_ready, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("tp_count", res_count, 100);
        check_eq("tp_empty", out_valid, 0);

        // Saturation on the narrow-counter instance.
        begin
            int cyc;
            cyc = 0;
            @(posedge clk); #1;
            sat_in_valid  = 1'b1;
            sat_out_ready = 1'b1;
            while (sat_xfers < 20 && cyc < 100) begin
                @(posedge clk); #1;
                sat_in_data = $urandom;
                sat_in_op   = 2'($urandom_range(0, 3));
                cyc++;
            end
            sat_in_valid  = 1'b0;
            sat_out_ready = 1'b0;
            check_eq("sat_xfers", sat_xfers >= 20, 1);
            @(negedge clk);
            check_eq("sat_final", sat_res_count, 15);
        end

        // Random stalls on both sides.
        do_reset(1);
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_data   = $urandom;
        end
        drain("drain_rand");

        // Reset with both stages full.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_eq("pre_rst_full", out_valid, 1);
        do_reset(3);
        @(negedge clk);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_count", res_count, 0);
        check_eq("mid_rst_zero", out_zero, 1);
        check_eq("mid_rst_in_ready", in_ready, 1);
        drain("drain_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
